// File: rtl/button_input.sv
// ---------------------------------------------------------------------------
// button_input
//
// Conditions three raw mechanical push buttons (mode, up, down) into clean,
// single-cycle press pulses for the downstream clock logic.
//
// Per channel: 2-flop synchronizer -> debounce counter -> debounced level ->
// registered rising-edge press pulse. The up and down channels also
// auto-repeat while held. Pressing up and down together is treated as
// "no input": neither channel pulses and both repeat machines stay idle.
//
// Parameters
//   DEBOUNCE_CYCLES : synchronized cycles of disagreement needed before the
//                     debounced level follows the input
//   REPEAT_DELAY    : cycles from a press pulse to the first repeat pulse
//   REPEAT_RATE     : cycles between subsequent repeat pulses
//
// Ports
//   clk           : single clock, all state on rising edge
//   rst           : asynchronous active-high reset
//   btn_mode_raw  : raw mode button, active-high, asynchronous to clk
//   btn_up_raw    : raw up button, active-high, asynchronous to clk
//   btn_down_raw  : raw down button, active-high, asynchronous to clk
//   button_mode   : one-cycle press pulse (never repeats)
//   button_up     : one-cycle press / auto-repeat pulse
//   button_down   : one-cycle press / auto-repeat pulse
//   btn_level     : debounced levels {down, up, mode}
//   dbg_state     : repeat FSM states {down[1:0], up[1:0]}
//                   (0 = IDLE, 1 = HOLD, 2 = REPEAT)
//
// Handshake: there is none; outputs are plain registered pulses. A pulse is
// high for exactly one clock and the consumer samples it on the next edge.
// ---------------------------------------------------------------------------
module button_input #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_RATE     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode_raw,
    input  logic       btn_up_raw,
    input  logic       btn_down_raw,
    output logic       button_mode,
    output logic       button_up,
    output logic       button_down,
    output logic [2:0] btn_level,
    output logic [3:0] dbg_state
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HC_W    = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    // Bit order everywhere: [0] = mode, [1] = up, [2] = down.
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [DB_W-1:0] db_cnt [3];
    logic [2:0]      level_q;
    logic [2:0]      rise;
    logic            both_high;

    // Repeat machines: index 0 = up, index 1 = down.
    rpt_state_t      st     [2];
    logic [HC_W-1:0] hcnt   [2];
    logic [1:0]      ud_pulse;

    assign raw       = {btn_down_raw, btn_up_raw, btn_mode_raw};
    assign rise      = btn_level & ~level_q;
    assign both_high = btn_level[1] & btn_level[2];

    assign button_up   = ud_pulse[0];
    assign button_down = ud_pulse[1];
    assign dbg_state   = {st[1], st[0]};

    // -----------------------------------------------------------------------
    // Synchronizer, debounce and press-pulse generation
    // -----------------------------------------------------------------------
    // The counter records how many consecutive synchronized cycles the input
    // has disagreed with the debounced level; once it holds DEBOUNCE_CYCLES
    // and the input still disagrees, the level flips on that edge. Any
    // agreement in between throws the count away, so short glitches vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= '0;
            sync2       <= '0;
            btn_level   <= '0;
            level_q     <= '0;
            button_mode <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1       <= raw;
            sync2       <= sync1;
            level_q     <= btn_level;
            button_mode <= rise[0];
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES)) begin
                    btn_level[i] <= ~btn_level[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Up/down auto-repeat state machines
    // -----------------------------------------------------------------------
    // Leaving IDLE with the level already high but no fresh rising edge only
    // happens after the opposite button was released from a two-button
    // press; that path re-arms the hold timer silently instead of pulsing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ud_pulse <= '0;
            for (int j = 0; j < 2; j++) begin
                st[j]   <= ST_IDLE;
                hcnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                ud_pulse[j] <= 1'b0;
                if (!btn_level[j+1] || both_high) begin
                    st[j]   <= ST_IDLE;
                    hcnt[j] <= '0;
                end else begin
                    case (st[j])
                        ST_IDLE: begin
                            st[j]       <= ST_HOLD;
                            hcnt[j]     <= '0;
                            ud_pulse[j] <= rise[j+1];
                        end
                        ST_HOLD: begin
                            if (hcnt[j] == HC_W'(REPEAT_DELAY - 1)) begin
                                st[j]       <= ST_REPEAT;
                                hcnt[j]     <= '0;
                                ud_pulse[j] <= 1'b1;
                            end else begin
                                hcnt[j] <= hcnt[j] + HC_W'(1);
                            end
                        end
                        ST_REPEAT: begin
                            if (hcnt[j] == HC_W'(REPEAT_RATE - 1)) begin
                                hcnt[j]     <= '0;
                                ud_pulse[j] <= 1'b1;
                            end else begin
                                hcnt[j] <= hcnt[j] + HC_W'(1);
                            end
                        end
                        default: begin
                            st[j]   <= ST_IDLE;
                            hcnt[j] <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
